// File: rtl/ppd_commutator.sv
// Polyphase commutator: distributes a high-rate sample stream over D lanes and
// emits one parallel frame per D accepted samples for the mul_add stage.
module ppd_commutator #(
    parameter int gp_decimation_factor = 4,
    parameter int gp_inp_width         = 8
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_an,
    input  logic                                         i_ena,
    input  logic                                         i_valid,
    input  logic [gp_inp_width-1:0]                      i_data,
    input  logic                                         i_sync,
    output logic [gp_decimation_factor*gp_inp_width-1:0] o_data,
    output logic                                         o_valid,
    output logic [$clog2(gp_decimation_factor)-1:0]      o_phase
);

    localparam int D  = gp_decimation_factor;
    localparam int W  = gp_inp_width;
    localparam int PW = $clog2(D);
    localparam logic [PW-1:0] LAST_PHASE = PW'(D - 1);

    logic [PW-1:0]    phase_r;
    logic [PW-1:0]    phase_nxt_s;
    logic [PW-1:0]    wr_lane_s;
    logic             accept_s;
    logic             frame_done_s;
    logic [W-1:0]     staging_r [D-1];
    logic [D*W-1:0]   frame_s;
    logic [D*W-1:0]   data_r;
    logic             valid_r;

    // Phase sequencing; a sync restarts the frame, its own sample (if any) being phase 0.
    always_comb begin
        accept_s     = i_ena & i_valid;
        phase_nxt_s  = phase_r;
        wr_lane_s    = phase_r;
        frame_done_s = 1'b0;
        if (i_ena) begin
            if (i_sync) begin
                wr_lane_s   = {PW{1'b0}};
                phase_nxt_s = i_valid ? PW'(1) : {PW{1'b0}};
            end else if (i_valid) begin
                if (phase_r == LAST_PHASE) begin
                    phase_nxt_s  = {PW{1'b0}};
                    frame_done_s = 1'b1;
                end else begin
                    phase_nxt_s = phase_r + PW'(1);
                end
            end else begin
                phase_nxt_s = phase_r;
            end
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Frame assembly: lane D-1 bypasses staging so the frame loads on its own edge.
    always_comb begin
        frame_s = {(D*W){1'b0}};
        for (int k = 0; k < D - 1; k++) begin
            frame_s[k*W +: W] = staging_r[k];
        end
        frame_s[(D-1)*W +: W] = i_data;
    end

    // Phase counter register.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            phase_r <= {PW{1'b0}};
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Staging lanes 0..D-2.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int k = 0; k < D - 1; k++) begin
                staging_r[k] <= {W{1'b0}};
            end
        end else begin
            for (int k = 0; k < D - 1; k++) begin
                if (accept_s && (wr_lane_s == PW'(k))) begin
                    staging_r[k] <= i_data;
                end
            end
        end
    end

    // Output frame and strobe; o_data holds between frames.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            data_r  <= {(D*W){1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= frame_done_s;
            if (frame_done_s) begin
                data_r <= frame_s;
            end
        end
    end

    assign o_data  = data_r;
    assign o_valid = valid_r;
    assign o_phase = phase_r;

endmodule

// File: tb/tb_ppd_commutator.sv
// Directed self-checking bench for ppd_commutator with D=4, W=8.
module tb_ppd_commutator;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        valid;
    logic [7:0]  data;
    logic        sync;
    logic [31:0] o_data;
    logic        o_valid;
    logic [1:0]  o_phase;

    int n_assert;
    int n_fail;

    ppd_commutator #(
        .gp_decimation_factor(4),
        .gp_inp_width        (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_an(rst_n),
        .i_ena   (ena),
        .i_valid (valid),
        .i_data  (data),
        .i_sync  (sync),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_phase (o_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] ph);
        chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, v});
        chk({tag, "_phase"}, {30'd0, o_phase}, {30'd0, ph});
    endtask

    task automatic send(input logic [7:0] d);
        valid = 1'b1;
        data  = d;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; ena = 1'b0; valid = 1'b0; data = 8'h00; sync = 1'b0;
        tick(); tick();
        chk("rst_data", o_data, 32'h0);
        chk_out("rst", 1'b0, 2'd0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Back-to-back frame
        send(8'h0A); chk_out("t1_s0", 1'b0, 2'd1);
        send(8'h0B); chk_out("t1_s1", 1'b0, 2'd2);
        send(8'h0C); chk_out("t1_s2", 1'b0, 2'd3);
        send(8'h0D); chk_out("t1_s3", 1'b1, 2'd0);
        chk("t1_data", o_data, 32'h0D0C0B0A);
        tick(); chk_out("t1_after", 1'b0, 2'd0);

        // Two-cycle bubbles between samples
        send(8'h0A); chk_out("t2_s0", 1'b0, 2'd1);
        tick(); tick(); chk_out("t2_g0", 1'b0, 2'd1);
        send(8'h0B); chk_out("t2_s1", 1'b0, 2'd2);
        tick(); tick(); chk_out("t2_g1", 1'b0, 2'd2);
        send(8'h0C); chk_out("t2_s2", 1'b0, 2'd3);
        tick(); tick(); chk_out("t2_g2", 1'b0, 2'd3);
        send(8'h0D); chk_out("t2_s3", 1'b1, 2'd0);
        chk("t2_data", o_data, 32'h0D0C0B0A);
        tick(); chk_out("t2_after", 1'b0, 2'd0);

        // Sync with a sample discards the partial frame
        send(8'h01); chk_out("t4_s0", 1'b0, 2'd1);
        send(8'h02); chk_out("t4_s1", 1'b0, 2'd2);
        sync = 1'b1; send(8'h11); sync = 1'b0;
        chk_out("t4_sync", 1'b0, 2'd1);
        send(8'h12); chk_out("t4_s2", 1'b0, 2'd2);
        send(8'h13); chk_out("t4_s3", 1'b0, 2'd3);
        send(8'h14); chk_out("t4_s4", 1'b1, 2'd0);
        chk("t4_data", o_data, 32'h14131211);

        // Sync without a sample returns to phase 0
        send(8'h55); chk_out("t4b_s0", 1'b0, 2'd1);
        sync = 1'b1; tick(); sync = 1'b0;
        chk_out("t4b_sync", 1'b0, 2'd0);
        chk("t4b_hold", o_data, 32'h14131211);

        // Enable low freezes state; sync and data ignored
        send(8'h0A); send(8'h0B);
        ena = 1'b0; valid = 1'b1; data = 8'hEE; sync = 1'b1;
        tick(); chk_out("t3_f0", 1'b0, 2'd2);
        tick(); tick(); chk_out("t3_f2", 1'b0, 2'd2);
        chk("t3_hold", o_data, 32'h14131211);
        ena = 1'b1; sync = 1'b0; valid = 1'b0;
        send(8'h0C); chk_out("t3_s2", 1'b0, 2'd3);
        send(8'h0D); chk_out("t3_s3", 1'b1, 2'd0);
        chk("t3_data", o_data, 32'h0D0C0B0A);

        // Asynchronous reset mid-frame
        send(8'h21); send(8'h22); send(8'h23);
        chk_out("t5_pre", 1'b0, 2'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_data", o_data, 32'h0);
        chk_out("t5_rst", 1'b0, 2'd0);
        tick();
        rst_n = 1'b1;
        send(8'h80); chk_out("t5_s0", 1'b0, 2'd1);
        send(8'hFF); send(8'h7F);
        send(8'h00); chk_out("t5_s3", 1'b1, 2'd0);
        chk("t5_data", o_data, 32'h007FFF80);

        // Sixteen consecutive samples, four frames
        valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data = 8'(i);
            tick();
            chk_out($sformatf("t6_%0d", i), (i % 4) == 3, 2'((i + 1) % 4));
            if ((i % 4) == 3) begin
                chk($sformatf("t6_frame%0d", i / 4), o_data,
                    {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
            end
        end
        valid = 1'b0;
        tick();
        chk_out("t6_end", 1'b0, 2'd0);
        chk("t6_hold", o_data, 32'h0F0E0D0C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ppd_commutator.md
PPD_COMMUTATOR -- requirements
Module: ppd_commutator

Interface
REQ-001 The block SHALL have parameter gp_decimation_factor, default 4, meaning number of polyphase branches D (legal range 2..16).
REQ-002 The block SHALL have parameter gp_inp_width, default 8, meaning width W of one two's-complement input sample.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the clock and reset are named as in the rest of the filt_ppi codebase, below.
REQ-004 i_clk  input  1  the single clock, rising-edge active.
REQ-005 i_rst_an  input  1  asynchronous active-low reset.
REQ-006 i_ena  input  1  global enable; when low, all state is frozen.
REQ-007 i_valid  input  1  i_data carries a sample this cycle.
REQ-008 i_data  input  W  input sample, high-rate stream.
REQ-009 i_sync  input  1  frame restart; the current sample, if any, becomes phase 0.
REQ-010 o_data  output  D*W  parallel frame for the downstream mul_add stage; lane k = bits [k*W +: W].
REQ-011 o_valid  output  1  one-cycle strobe; o_data holds a new complete frame.
REQ-012 o_phase  output  clog2(D)  lane index the next accepted sample will fill.

Function
REQ-013 A sample SHALL be accepted on a rising edge when i_ena=1 and i_valid=1.
REQ-014 The phase counter SHALL increment by 1 on each accepted sample and wrap from D-1 to 0; it SHALL not change otherwise.
REQ-015 An accepted sample at phase p SHALL be written to staging lane p; lanes 0..D-2 are registered, and lane D-1 SHALL be taken directly from i_data.
REQ-016 On the edge accepting phase D-1, o_data SHALL load {i_data, staging lanes D-2..0}, and o_valid SHALL be 1 for exactly the following cycle, giving a latency of 1 cycle from the last sample.
REQ-017 o_valid SHALL be 0 on every other cycle, including cycles with i_ena=0.
REQ-018 o_data SHALL hold its value between frames; staging SHALL never be visible on o_data until the frame completes.
REQ-019 o_phase SHALL equal the registered phase counter.
REQ-020 Samples SHALL pass bit-exact, without arithmetic, sign change or truncation.
REQ-021 i_sync=1, i_ena=1, i_valid=0: the counter SHALL go to 0, any partial frame is discarded and no o_valid is generated.
REQ-022 i_sync=1, i_ena=1, i_valid=1: the sample SHALL be written to lane 0, the counter SHALL become 1 and no o_valid is generated.
REQ-023 i_sync SHALL be ignored when i_ena=0.
REQ-024 Valid gaps (bubbles) of any length SHALL not affect frame content or alignment.
REQ-025 Back-to-back frames SHALL be supported at full rate: one o_valid every D accepted samples with no lost sample.

Reset
REQ-026 While i_rst_an=0, the following SHALL be forced asynchronously: phase counter=0, staging=0, o_data=0, o_valid=0, o_phase=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first sample accepted after release SHALL be phase 0.
REQ-028 The first active edge after reset release SHALL behave as a normal cycle, with no extra flush cycle.

Verification (D=4, W=8)
REQ-029 Reset, then 0x0A,0x0B,0x0C,0x0D valid on consecutive cycles -> o_data=0x0D0C0B0A, with o_valid high one cycle, the cycle after the 0x0D edge.
REQ-030 Same samples with 2-cycle valid gaps -> identical o_data, a single o_valid pulse, and o_phase stepping 0,1,2,3,0.
REQ-031 i_ena=0 for 3 cycles after two samples (i_valid held high) -> o_phase held at 2 and o_valid=0; after resume, 0x0C,0x0D complete the frame 0x0D0C0B0A.
REQ-032 Samples 0x01,0x02, then i_sync with 0x11, then 0x12,0x13,0x14 -> o_data=0x14131211 and no o_valid for the discarded partial frame.
REQ-033 Reset asserted asynchronously at phase 3 -> o_data=0, o_valid=0, o_phase=0 immediately; after release, 0x80,0xFF,0x7F,0x00 -> o_data=0x007FFF80.
REQ-034 16 consecutive samples 0x00..0x0F -> 4 o_valid pulses spaced 4 cycles apart, with frames 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
